trip_odometer: RTL
==================

Name: trip_odometer

Overview:
- Sits directly downstream of the engine model.
- Integrates speed_kmh on every 10 Hz tick into a BCD odometer (6 digits) and a resettable trip meter (4 digits), both in 0.1 km units.
- Runs a display-mode FSM (SPEED/ODO/TRIP) that drives the 32-bit nibble word consumed by the 8-digit seven-seg display driver.
- Speed is converted to BCD sequentially, so the display path needs no dividers.

Parameters:
- TICK_HZ, 10, rate of tick_in. Distance threshold STEP_TH = 360*TICK_HZ (3600 = 0.1 km).
- ODO_INIT_BCD, 24'h000000, odometer value loaded on reset (6 BCD digits). Used for the wrap test.
- SERVICE_INTERVAL, 16'd50000, odometer tenths between service reminders (optional feature only).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- tick_in  in  1  one-cycle pulse at TICK_HZ (tick_10hz).
- speed_kmh  in  9  current speed, km/h, 0..511.
- trip_clr  in  1  one-cycle pulse (debounced btn_rise): zero the trip meter.
- mode_next  in  1  one-cycle pulse: advance the display mode.
- service_ack  in  1  one-cycle pulse: clear service_due.
- odo_bcd  out  24  odometer, 6 BCD digits, tenths of km.
- trip_bcd  out  16  trip, 4 BCD digits, tenths of km.
- disp_value  out  32  8 nibbles for the display; 0xF = blank.
- disp_mode  out  2  0 = SPEED, 1 = ODO, 2 = TRIP.
- service_due  out  1  service reminder flag.

Behaviour:
- Reset (sync, active-high, also mid-operation) sets:
  - acc = 0, odo_bcd = ODO_INIT_BCD, trip_bcd = 0
  - disp_mode = SPEED, speed BCD = 000, service_due = 0
  - converter returned to IDLE
- Accumulator: 13-bit acc.
  - On tick_in: sum = acc + speed_kmh.
  - If sum >= STEP_TH: acc <= sum - STEP_TH and step = 1, else acc <= sum.
  - At most one step per tick, since max speed 511 < 3600.
  - speed 0 leaves acc unchanged.
- Step takes effect in the same cycle as acc update (registered; visible on the next cycle). On step:
  - odo_bcd and trip_bcd each increment by 1 in BCD with digit carry.
  - odo wraps 999999 -> 000000.
  - trip wraps 9999 -> 0000.
- trip_clr: trip_bcd <= 0 next cycle. If it coincides with a step, the clear wins (trip = 0000) and odo still increments.
- Mode FSM: on mode_next, SPEED -> ODO -> TRIP -> SPEED. Encoding value 3 is illegal and recovers to SPEED on the next cycle. mode_next and trip_clr in the same cycle are both honoured.
- Speed BCD conversion: sub-module bin2bcd_seq (shift-add-3, 9 iterations).
  - FSM states: IDLE, SHIFT (9 cycles), DONE (1 cycle).
  - Started on tick_in, latching speed_kmh.
  - Result registered at DONE, 11 cycles after tick_in.
  - tick_in arriving while busy is ignored.
- disp_value is a registered mux, 1 cycle after a mode or data change:
  - SPEED: 0xFFFFF, speed hundreds, tens, units (nibbles [11:0]).
  - ODO: nibble7 = 0xA, nibble6 = 0xF, nibbles [23:0] = odo_bcd.
  - TRIP: nibble7 = 0xB, nibbles [27:16] = 0xFFF, nibbles [15:0] = trip_bcd.

Optional Feature:
- Macro: SERVICE_REMINDER_EN.
- With the macro defined:
  - A 16-bit binary counter counts steps.
  - When it reaches SERVICE_INTERVAL-1 and a step occurs, the counter is set to 0 and service_due is set to 1 (sticky).
  - service_ack clears service_due next cycle. If ack coincides with a new set, set wins.
- Without the macro: service_due is tied to 0, service_ack is ignored, and no counter is synthesised.

Decomposition:
- Shared package dashboard_pkg holds:
  - mode encodings MODE_SPEED/MODE_ODO/MODE_TRIP
  - BLANK_NIBBLE = 4'hF, TAG_ODO = 4'hA, TAG_TRIP = 4'hB
  - STEP_TH derivation
- One sub-module: bin2bcd_seq (9-bit in, 12-bit BCD out, start/busy/done).
- BCD digit increment is a function in the package.

Test Plan:
- Reset, speed 360, 10 ticks -> odo_bcd 000000 after tick 9; 000001 and trip 0001 one cycle after tick 10; acc = 0.
- ODO_INIT_BCD = 24'h999999, speed 360, 10 ticks -> odo_bcd 000000 (wrap); trip 0001.
- Trip at 0009 with acc 3240, speed 360, tick coinciding with trip_clr -> trip 0000, odo +1.
- Speed 123, one tick -> 11 cycles later disp_value = 32'hFFFFF123; second tick_in at cycle 5 ignored.
- mode_next x4 from reset -> disp_mode 1,2,0,1. In ODO with odo 000042: disp_value = 32'hAF000042.
- SERVICE_REMINDER_EN, SERVICE_INTERVAL = 3, 3 steps -> service_due = 1. Ack -> 0. Ack on the same cycle as the 6th step -> stays 1.

Source files
------------

// File: rtl/dashboard_pkg.sv
// Shared dashboard definitions: display modes, display nibble codes, distance
// step threshold and the BCD helpers used by the odometer and speed converter.
package dashboard_pkg;

   typedef enum logic [1:0] {
      MODE_SPEED = 2'd0,
      MODE_ODO   = 2'd1,
      MODE_TRIP  = 2'd2
   } disp_mode_e;

   localparam logic [3:0] BLANK_NIBBLE = 4'hF;
   localparam logic [3:0] TAG_ODO      = 4'hA;
   localparam logic [3:0] TAG_TRIP     = 4'hB;

   // km/h integrated per tick: 0.1 km = 360 km/h * 1 s, scaled by the tick rate
   localparam int STEP_PER_HZ = 360;

   function automatic logic [12:0] step_th(input int tick_hz);
      return 13'(STEP_PER_HZ * tick_hz);
   endfunction

   // Returns {carry_out, digit}; a digit of 9 (or an illegal code) rolls to 0.
   function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d, input logic cin);
      logic [4:0] r;
      if (!cin) begin
         r = {1'b0, d};
      end else if (d >= 4'd9) begin
         r = {1'b1, 4'd0};
      end else begin
         r = {1'b0, d + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [3:0] dabble_adj(input logic [3:0] d);
      logic [3:0] r;
      if (d >= 4'd5) begin
         r = d + 4'd3;
      end else begin
         r = d;
      end
      return r;
   endfunction

endpackage

// File: rtl/trip_odometer_bin2bcd_seq.sv
// Sequential 9-bit binary to 3-digit BCD converter (shift-add-3, one bit per
// cycle). A start pulse is only accepted while idle.
module bin2bcd_seq
   import dashboard_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [8:0]  bin,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd
);

   typedef enum logic [1:0] {
      CV_IDLE  = 2'd0,
      CV_SHIFT = 2'd1,
      CV_DONE  = 2'd2
   } cv_state_e;

   cv_state_e   r_state;
   logic [8:0]  r_bin;
   logic [11:0] r_work;
   logic [3:0]  r_cnt;
   logic [11:0] r_bcd;
   logic        r_done;
   logic [11:0] w_adj;
   logic        w_unused_msb;

   always_comb begin
      w_adj = {dabble_adj(r_work[11:8]), dabble_adj(r_work[7:4]), dabble_adj(r_work[3:0])};
      w_unused_msb = w_adj[11];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CV_IDLE;
         r_bin   <= 9'd0;
         r_work  <= 12'd0;
         r_cnt   <= 4'd0;
         r_bcd   <= 12'd0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            CV_IDLE: begin
               if (start) begin
                  r_bin   <= bin;
                  r_work  <= 12'd0;
                  r_cnt   <= 4'd0;
                  r_state <= CV_SHIFT;
               end
            end
            CV_SHIFT: begin
               // adjust digits >= 5 before shifting in the next binary bit
               r_work <= {w_adj[10:0], r_bin[8]};
               r_bin  <= {r_bin[7:0], 1'b0};
               r_cnt  <= r_cnt + 4'd1;
               if (r_cnt == 4'd8) begin
                  r_state <= CV_DONE;
               end
            end
            CV_DONE: begin
               r_bcd   <= r_work;
               r_done  <= 1'b1;
               r_state <= CV_IDLE;
            end
            default: begin
               r_state <= CV_IDLE;
            end
         endcase
      end
   end

   assign busy = (r_state != CV_IDLE);
   assign done = r_done;
   assign bcd  = r_bcd;

endmodule

// File: rtl/trip_odometer.sv
// Odometer/trip integrator with display-mode FSM and registered display word.
// Optional service reminder enabled by defining SERVICE_REMINDER_EN.
module trip_odometer
   import dashboard_pkg::*;
#(
   parameter int          TICK_HZ          = 10,
   parameter logic [23:0] ODO_INIT_BCD     = 24'h000000,
   parameter logic [15:0] SERVICE_INTERVAL = 16'd50000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_in,
   input  logic [8:0]  speed_kmh,
   input  logic        trip_clr,
   input  logic        mode_next,
   input  logic        service_ack,
   output logic [23:0] odo_bcd,
   output logic [15:0] trip_bcd,
   output logic [31:0] disp_value,
   output logic [1:0]  disp_mode,
   output logic        service_due
);

   localparam logic [12:0] STEP_TH = step_th(TICK_HZ);

   logic [12:0] r_acc;
   logic [23:0] r_odo;
   logic [15:0] r_trip;
   disp_mode_e  r_mode;
   logic [31:0] r_disp;

   logic [13:0] w_sum;
   logic        w_step;
   logic [12:0] w_acc_next;
   logic [23:0] w_odo_inc;
   logic [15:0] w_trip_inc;
   logic        w_conv_busy;
   logic        w_conv_done;
   logic        w_conv_start;
   logic [11:0] w_speed_bcd;
   logic        w_unused_conv;

   always_comb begin
      w_sum      = {1'b0, r_acc} + {5'd0, speed_kmh};
      w_step     = 1'b0;
      w_acc_next = r_acc;
      if (tick_in) begin
         if (w_sum >= {1'b0, STEP_TH}) begin
            w_step     = 1'b1;
            w_acc_next = w_sum[12:0] - STEP_TH;
         end else begin
            w_acc_next = w_sum[12:0];
         end
      end else begin
         w_acc_next = r_acc;
      end
   end

   // carry out of the top digit is dropped, giving the 999999 -> 000000 wrap
   always_comb begin
      logic       w_c;
      logic [4:0] w_d;
      w_c       = 1'b1;
      w_d       = 5'd0;
      w_odo_inc = r_odo;
      for (int i = 0; i < 6; i++) begin
         w_d = bcd_digit_inc(r_odo[i*4 +: 4], w_c);
         w_odo_inc[i*4 +: 4] = w_d[3:0];
         w_c = w_d[4];
      end
   end

   always_comb begin
      logic       w_c;
      logic [4:0] w_d;
      w_c        = 1'b1;
      w_d        = 5'd0;
      w_trip_inc = r_trip;
      for (int i = 0; i < 4; i++) begin
         w_d = bcd_digit_inc(r_trip[i*4 +: 4], w_c);
         w_trip_inc[i*4 +: 4] = w_d[3:0];
         w_c = w_d[4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc  <= 13'd0;
         r_odo  <= ODO_INIT_BCD;
         r_trip <= 16'd0;
      end else begin
         r_acc <= w_acc_next;
         if (w_step) begin
            r_odo <= w_odo_inc;
         end
         if (trip_clr) begin
            r_trip <= 16'd0;
         end else if (w_step) begin
            r_trip <= w_trip_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= MODE_SPEED;
      end else begin
         case (r_mode)
            MODE_SPEED: if (mode_next) r_mode <= MODE_ODO;
            MODE_ODO:   if (mode_next) r_mode <= MODE_TRIP;
            MODE_TRIP:  if (mode_next) r_mode <= MODE_SPEED;
            default:    r_mode <= MODE_SPEED;
         endcase
      end
   end

   assign w_conv_start = tick_in & ~w_conv_busy;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (w_conv_start),
      .bin   (speed_kmh),
      .busy  (w_conv_busy),
      .done  (w_conv_done),
      .bcd   (w_speed_bcd)
   );

   assign w_unused_conv = w_conv_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_disp <= {{5{BLANK_NIBBLE}}, 12'h000};
      end else begin
         case (r_mode)
            MODE_SPEED: r_disp <= {{5{BLANK_NIBBLE}}, w_speed_bcd};
            MODE_ODO:   r_disp <= {TAG_ODO, BLANK_NIBBLE, r_odo};
            MODE_TRIP:  r_disp <= {TAG_TRIP, {3{BLANK_NIBBLE}}, r_trip};
            default:    r_disp <= {{5{BLANK_NIBBLE}}, w_speed_bcd};
         endcase
      end
   end

`ifdef SERVICE_REMINDER_EN
   logic [15:0] r_svc_cnt;
   logic        r_svc_due;
   logic        w_svc_set;

   assign w_svc_set = w_step && (r_svc_cnt == (SERVICE_INTERVAL - 16'd1));

   // a new reminder takes priority over a simultaneous acknowledge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_svc_cnt <= 16'd0;
         r_svc_due <= 1'b0;
      end else begin
         if (w_svc_set) begin
            r_svc_cnt <= 16'd0;
            r_svc_due <= 1'b1;
         end else begin
            if (w_step) begin
               r_svc_cnt <= r_svc_cnt + 16'd1;
            end
            if (service_ack) begin
               r_svc_due <= 1'b0;
            end
         end
      end
   end

   assign service_due = r_svc_due;
`else
   logic w_unused_svc;
   assign w_unused_svc = ^{service_ack, SERVICE_INTERVAL};
   assign service_due  = 1'b0;
`endif

   assign odo_bcd    = r_odo;
   assign trip_bcd   = r_trip;
   assign disp_value = r_disp;
   assign disp_mode  = r_mode;

endmodule
